// File: rtl/acc_wb_sequencer.sv
// Accumulator write-back sequencer: takes one decoded instruction at a time through
// execute, the data-memory handshake and write-back, then signals retirement.
module acc_wb_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [2:0]       op_class,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic [2:0]       acc_sel,
    output logic             acc_we,
    output logic             instr_done,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] retired_cnt
);
    localparam int              TO_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(MEM_TIMEOUT - 1);
    localparam logic [2:0]      SEL_NONE = 3'b111;
    localparam logic [2:0]      SEL_MEM  = 3'b100;
    localparam logic [2:0]      OP_REG_MAX = 3'd3;
    localparam logic [2:0]      OP_LOAD  = 3'd4;
    localparam logic [2:0]      OP_STORE = 3'd5;
    localparam logic [2:0]      OP_NOP   = 3'd6;
    localparam logic [2:0]      OP_HALT  = 3'd7;

    typedef enum logic [2:0] {IDLE, EXEC, MEM_WAIT, WB, HALT} state_t;

    state_t           r_state;
    logic [2:0]       r_op;
    logic [TO_W-1:0]  r_tmo;
    logic [2:0]       r_acc_sel;
    logic             r_acc_we;
    logic             r_mem_req;
    logic             r_mem_we;
    logic             r_done;
    logic             r_halted;
    logic             r_err;
    logic [CNT_W-1:0] r_retired;

    // Outputs are loaded on the edge that enters the state they belong to, so the
    // write/retire pulses line up with EXEC and WB without any input-to-output path.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_op      <= '0;
            r_tmo     <= '0;
            r_acc_sel <= SEL_NONE;
            r_acc_we  <= 1'b0;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_done    <= 1'b0;
            r_halted  <= 1'b0;
            r_err     <= 1'b0;
            r_retired <= '0;
        end else begin
            r_acc_sel <= SEL_NONE;
            r_acc_we  <= 1'b0;
            r_done    <= 1'b0;
            if (r_done) begin
                r_retired <= r_retired + CNT_W'(1);
            end

            unique case (r_state)
                IDLE: begin
                    if (instr_valid) begin
                        r_op    <= op_class;
                        r_state <= EXEC;
                        if (op_class <= OP_REG_MAX) begin
                            r_acc_sel <= op_class;
                            r_acc_we  <= 1'b1;
                            r_done    <= 1'b1;
                        end else if (op_class == OP_NOP || op_class == OP_HALT) begin
                            r_done <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    case (r_op)
                        OP_LOAD, OP_STORE: begin
                            r_state   <= MEM_WAIT;
                            r_mem_req <= 1'b1;
                            r_mem_we  <= (r_op == OP_STORE);
                        end
                        OP_HALT: begin
                            r_state  <= HALT;
                            r_halted <= 1'b1;
                        end
                        default: r_state <= IDLE;
                    endcase
                end
                MEM_WAIT: begin
                    r_tmo <= r_tmo + TO_W'(1);
                    // An ack on the last allowed cycle wins over the timeout.
                    if (mem_ack || r_tmo == TO_LAST) begin
                        r_tmo     <= '0;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_done    <= 1'b1;
                        if (!mem_ack) begin
                            r_err   <= 1'b1;
                            r_state <= IDLE;
                        end else if (r_op == OP_LOAD) begin
                            r_state   <= WB;
                            r_acc_sel <= SEL_MEM;
                            r_acc_we  <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                WB:      r_state <= IDLE;
                HALT:    r_state <= HALT;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign instr_ready = (r_state == IDLE);
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign acc_sel     = r_acc_sel;
    assign acc_we      = r_acc_we;
    assign instr_done  = r_done;
    assign halted      = r_halted;
    assign mem_err     = r_err;
    assign retired_cnt = r_retired;
endmodule

// File: tb/tb_acc_wb_sequencer.sv
// Bench for acc_wb_sequencer: each accepted instruction fills a cycle-indexed schedule
// of expected outputs, which a single process compares against the DUT every cycle.
module tb_acc_wb_sequencer;
    localparam int NCYC  = 8192;
    localparam int TMO   = 15;
    localparam int NEVER = 1 << 30;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        instr_valid;
    logic        mem_ack;
    logic [2:0]  op_class;
    logic        instr_ready, mem_req, mem_we, acc_we, instr_done, halted, mem_err;
    logic [2:0]  acc_sel;
    logic [15:0] retired_cnt;
    logic        sReady, sReq, sMemWe, sWe, sDone, sHalted, sErr;
    logic [2:0]  sSel;
    logic [2:0]  smallCnt;

    acc_wb_sequencer #(.MEM_TIMEOUT(TMO), .CNT_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .op_class(op_class), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
        .acc_sel(acc_sel), .acc_we(acc_we), .instr_done(instr_done), .halted(halted),
        .mem_err(mem_err), .retired_cnt(retired_cnt)
    );

    // Narrow-counter copy so the wrap from all-ones to zero is reached quickly.
    acc_wb_sequencer #(.MEM_TIMEOUT(TMO), .CNT_W(3)) dutSmall (
        .Clk(Clk), .Reset(Reset), .instr_valid(instr_valid), .instr_ready(sReady),
        .op_class(op_class), .mem_ack(mem_ack), .mem_req(sReq), .mem_we(sMemWe),
        .acc_sel(sSel), .acc_we(sWe), .instr_done(sDone), .halted(sHalted),
        .mem_err(sErr), .retired_cnt(smallCnt)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    logic [2:0] eSel   [NCYC];
    bit         eWe    [NCYC];
    bit         eDone  [NCYC];
    bit         eReq   [NCYC];
    bit         eMemWe [NCYC];
    bit         eReady [NCYC];
    bit         eHalt  [NCYC];
    bit         eErr   [NCYC];
    bit         eRst   [NCYC];

    int checks = 0;
    int failures = 0;
    int modelCnt = 0;
    bit checkEn = 1'b0;
    int freeAt = NEVER;
    int memLo = 1;
    int memHi = 0;
    int ackAt = -1;

    task automatic checkOutput(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic ackFor(int t);
        if (t >= memLo && t <= memHi) return (t == ackAt);
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic clearFrom(int t);
        for (int k = t; k < NCYC; k++) begin
            eSel[k] = 3'b111; eWe[k] = 0; eDone[k] = 0; eReq[k] = 0; eMemWe[k] = 0;
            eReady[k] = 1; eHalt[k] = 0; eErr[k] = 0; eRst[k] = 0;
        end
    endtask

    // Expected timeline of one instruction accepted in cycle n; d is the MEM_WAIT
    // cycle (1..TMO) carrying the ack, 0 meaning the memory never answers.
    task automatic schedule(int n, logic [2:0] op, int d);
        int last;
        eReady[n+1] = 0;
        if (op <= 3'd3) begin
            eSel[n+1] = op; eWe[n+1] = 1; eDone[n+1] = 1; freeAt = n + 2;
        end else if (op == 3'd6) begin
            eDone[n+1] = 1; freeAt = n + 2;
        end else if (op == 3'd7) begin
            eDone[n+1] = 1;
            for (int k = n + 1; k < NCYC; k++) eReady[k] = 0;
            for (int k = n + 2; k < NCYC; k++) eHalt[k] = 1;
            freeAt = NEVER;
        end else begin
            last = (d > 0) ? n + 1 + d : n + 1 + TMO;
            for (int k = n + 2; k <= last; k++) begin
                eReq[k] = 1; eMemWe[k] = (op == 3'd5); eReady[k] = 0;
            end
            eDone[last+1] = 1;
            if (d == 0) begin
                for (int k = last + 1; k < NCYC; k++) eErr[k] = 1;
                freeAt = last + 1;
            end else if (op == 3'd4) begin
                eSel[last+1] = 3'd4; eWe[last+1] = 1; eReady[last+1] = 0;
                freeAt = last + 2;
            end else begin
                freeAt = last + 1;
            end
            memLo = n + 2; memHi = last; ackAt = (d > 0) ? last : -1;
        end
    endtask

    task automatic idleCycle();
        instr_valid = (cyc < freeAt) ? 1'($urandom_range(0, 1)) : 1'b0;
        op_class = 3'($urandom_range(0, 7));
        mem_ack = ackFor(cyc);
        tick();
    endtask

    task automatic applyStimulus(logic [2:0] op, int d, output int nAcc);
        int guard = 0;
        while (cyc < freeAt && guard < 64) begin
            idleCycle();
            guard++;
        end
        nAcc = cyc;
        if (cyc < freeAt) begin
            checks++;
            failures++;
            $display("[TB] FAIL issue_wait cycle=%0d actual=busy expected=idle", cyc);
        end else begin
            instr_valid = 1'b1;
            op_class = op;
            mem_ack = ackFor(cyc);
            schedule(cyc, op, d);
            tick();
            instr_valid = 1'b0;
        end
    endtask

    task automatic applyReset();
        Reset = 1'b1;
        instr_valid = 1'($urandom_range(0, 1));
        op_class = 3'($urandom_range(0, 7));
        mem_ack = 1'($urandom_range(0, 1));
        clearFrom(cyc + 1);
        eRst[cyc+1] = 1'b1;
        freeAt = cyc + 1; memLo = 1; memHi = 0; ackAt = -1;
        tick();
        Reset = 1'b0;
        instr_valid = 1'b0;
    endtask

    task automatic measure(int nAcc, int len, output int reqN, output int weN,
                           output int doneN, output int lat, output int reqWeN);
        reqN = 0; weN = 0; doneN = 0; lat = -1; reqWeN = 0;
        for (int i = 0; i < len; i++) begin
            reqN += int'(mem_req);
            weN += int'(acc_we);
            doneN += int'(instr_done);
            reqWeN += int'(mem_req && mem_we);
            if (acc_we && lat < 0) lat = cyc - nAcc;
            idleCycle();
        end
    endtask

    // Cycle-by-cycle comparison of both instances against the schedule.
    always @(negedge Clk) begin
        if (checkEn) begin
            if (eRst[cyc]) modelCnt = 0;
            checkOutput("acc_sel", 16'(acc_sel), 16'(eSel[cyc]));
            checkOutput("acc_we", 16'(acc_we), 16'(eWe[cyc]));
            checkOutput("instr_done", 16'(instr_done), 16'(eDone[cyc]));
            checkOutput("mem_req", 16'(mem_req), 16'(eReq[cyc]));
            checkOutput("mem_we", 16'(mem_we), 16'(eMemWe[cyc]));
            checkOutput("instr_ready", 16'(instr_ready), 16'(eReady[cyc]));
            checkOutput("halted", 16'(halted), 16'(eHalt[cyc]));
            checkOutput("mem_err", 16'(mem_err), 16'(eErr[cyc]));
            checkOutput("retired_cnt", retired_cnt, 16'(modelCnt));
            checkOutput("small_cnt", 16'(smallCnt), 16'(modelCnt % 8));
            checkOutput("small_flags",
                        16'({sReady, sReq, sMemWe, sWe, sDone, sHalted, sErr, sSel}),
                        16'({eReady[cyc], eReq[cyc], eMemWe[cyc], eWe[cyc], eDone[cyc],
                             eHalt[cyc], eErr[cyc], eSel[cyc]}));
            if (eDone[cyc]) modelCnt++;
        end
    end

    initial begin
        int n, reqN, weN, doneN, lat, reqWeN;
        logic [2:0] bbOps [4];
        logic [2:0] rop;
        int rd;

        bbOps = '{3'd3, 3'd1, 3'd0, 3'd2};
        Reset = 1'b1; instr_valid = 1'b0; op_class = 3'd0; mem_ack = 1'b0;
        clearFrom(0);
        repeat (3) tick();
        applyReset();
        checkEn = 1'b1;

        checkOutput("rst_ready", 16'(instr_ready), 16'd1);
        checkOutput("rst_sel", 16'(acc_sel), 16'd7);
        checkOutput("rst_cnt", retired_cnt, 16'd0);

        // Back-to-back register-class ops write in the cycle after acceptance.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(bbOps[i], 0, n);
            checkOutput("bb_we", 16'(acc_we), 16'd1);
            checkOutput("bb_sel", 16'(acc_sel), 16'(bbOps[i]));
            checkOutput("bb_ready", 16'(instr_ready), 16'd0);
        end
        idleCycle();
        checkOutput("bb_cnt", retired_cnt, 16'd4);

        applyStimulus(3'd4, 3, n);
        measure(n, 25, reqN, weN, doneN, lat, reqWeN);
        checkOutput("load_req_cycles", 16'(reqN), 16'd3);
        checkOutput("load_latency", 16'(lat), 16'd5);
        checkOutput("load_we_cycles", 16'(weN), 16'd1);

        applyStimulus(3'd5, 1, n);
        measure(n, 20, reqN, weN, doneN, lat, reqWeN);
        checkOutput("store_req_we", 16'(reqWeN), 16'd1);
        checkOutput("store_we_cycles", 16'(weN), 16'd0);
        checkOutput("store_done", 16'(doneN), 16'd1);

        applyStimulus(3'd4, 0, n);
        measure(n, 25, reqN, weN, doneN, lat, reqWeN);
        checkOutput("tmo_req_cycles", 16'(reqN), 16'd15);
        checkOutput("tmo_we_cycles", 16'(weN), 16'd0);
        checkOutput("tmo_done", 16'(doneN), 16'd1);
        checkOutput("tmo_err", 16'(mem_err), 16'd1);

        applyReset();
        applyStimulus(3'd4, 15, n);
        measure(n, 25, reqN, weN, doneN, lat, reqWeN);
        checkOutput("late_ack_err", 16'(mem_err), 16'd0);
        checkOutput("late_ack_we", 16'(weN), 16'd1);
        checkOutput("late_ack_latency", 16'(lat), 16'd17);

        applyStimulus(3'd4, 0, n);
        repeat (4) idleCycle();
        applyReset();
        checkOutput("rst_mid_req", 16'(mem_req), 16'd0);
        measure(n, 20, reqN, weN, doneN, lat, reqWeN);
        checkOutput("rst_mid_we", 16'(weN), 16'd0);

        applyReset();
        repeat (8) applyStimulus(3'd6, 0, n);
        idleCycle();
        checkOutput("nop_cnt", retired_cnt, 16'd8);
        checkOutput("nop_wrap", 16'(smallCnt), 16'd0);

        applyStimulus(3'd7, 0, n);
        measure(n, 8, reqN, weN, doneN, lat, reqWeN);
        checkOutput("halt_flag", 16'(halted), 16'd1);
        checkOutput("halt_ready", 16'(instr_ready), 16'd0);
        checkOutput("halt_done", 16'(doneN), 16'd1);
        applyReset();
        checkOutput("halt_rst_flag", 16'(halted), 16'd0);
        checkOutput("halt_rst_ready", 16'(instr_ready), 16'd1);
        checkOutput("halt_rst_sel", 16'(acc_sel), 16'd7);

        for (int i = 0; i < 400 && cyc < 6500; i++) begin
            rop = ($urandom_range(0, 19) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
            rd = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, TMO));
            repeat ($urandom_range(0, 2)) idleCycle();
            applyStimulus(rop, rd, n);
            if (rop == 3'd7) begin
                repeat ($urandom_range(2, 6)) idleCycle();
                applyReset();
            end else if ($urandom_range(0, 29) == 0) begin
                repeat ($urandom_range(0, 8)) idleCycle();
                applyReset();
            end
        end
        repeat (25) idleCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
